// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage and the loop stream
// detector that sits beside it: FSM encoding, default PC/NOP values, the
// conditional-branch opcode and a saturating-increment helper.
package if_fetch_stage_pkg;

  // RUN      : sequential fetch from instruction memory
  // STREAM   : loop detector supplies instructions, memory fetch suspended
  // REDIRECT : one-cycle refetch after a PC change (mispredict, flush, reset)
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STREAM   = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [6:0]  OPCODE_BRANCH     = 7'b110_0011;
  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] STREAM_COUNT_MAX  = 32'hFFFF_FFFF;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == STREAM_COUNT_MAX) ? value : value + 32'd1;
  endfunction

endpackage : if_fetch_stage_pkg

// File: rtl/if_fetch_stage_branch_imm_decode.sv
// Combinational B-type immediate extractor. Produces the branch offset in
// words (byte offset arithmetically shifted right by 2) for conditional
// branches and zero for every other instruction. Shared with the loop
// detector so both agree on how a loop's back-edge distance is measured.
module branch_imm_decode
  import if_fetch_stage_pkg::*;
(
  input  logic [31:0] i_instruction,
  output logic [31:0] o_word_offset
);

  logic        w_is_branch;
  logic [12:0] w_b_imm;
  logic        w_unused_fields;

  assign w_is_branch = (i_instruction[6:0] == OPCODE_BRANCH);

  // B-immediate layout: imm[12|10:5] in [31:25], imm[4:1|11] in [11:7],
  // imm[0] is implicitly zero.
  assign w_b_imm = {i_instruction[31], i_instruction[7],
                    i_instruction[30:25], i_instruction[11:8], 1'b0};

  // Sign-extend then shift right by 2 arithmetically; written as a direct
  // bit selection so no signed intermediate is needed. imm[1:0] drop out.
  assign o_word_offset = w_is_branch ? {{21{w_b_imm[12]}}, w_b_imm[12:2]}
                                     : 32'h0000_0000;

  // rs1/rs2/funct3 carry no offset information.
  assign w_unused_fields = ^i_instruction[24:12];

endmodule : branch_imm_decode

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with a one-cycle-latency instruction memory and
// a loop stream detector bypass. The pc register holds the next address to
// fetch; fetch_pc/inflight track the single read whose data arrives on
// imem_rdata in the following cycle. Redirects (mispredict, loop-detector
// flush, leaving STREAM) always pass through REDIRECT, which issues the
// first fetch of the new path while IF/ID carries a bubble.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  // instruction memory
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  // execute-stage redirect
  input  logic        ex_mispredict,
  input  logic [31:0] ex_target_pc,
  // hazard unit
  input  logic        hazard_stall,
  // loop stream detector
  input  logic        lsd_block,
  input  logic        lsd_flush,
  input  logic [31:0] lsd_new_pc,
  input  logic [31:0] lsd_instruction,
  // IF/ID pipeline register
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_immediate,
  output logic        ifid_valid,
  output logic [31:0] stream_count
);

  // Architectural state
  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_fetch_pc;
  logic         r_inflight;
  logic [31:0]  r_ifid_pc;
  logic [31:0]  r_ifid_instruction;
  logic [31:0]  r_ifid_immediate;
  logic         r_ifid_valid;
  logic [31:0]  r_stream_count;

  // Next-state values and combinational memory request
  fetch_state_t w_state_next;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_fetch_pc_next;
  logic         w_inflight_next;
  logic [31:0]  w_ifid_pc_next;
  logic [31:0]  w_ifid_instr_next;
  logic [31:0]  w_ifid_imm_next;
  logic         w_ifid_valid_next;
  logic [31:0]  w_stream_count_next;
  logic [31:0]  w_imem_addr;
  logic         w_imem_req;

  // Immediate is decoded from the word entering IF/ID so it is registered
  // alongside the instruction it belongs to.
  branch_imm_decode u_branch_imm_decode (
    .i_instruction (w_ifid_instr_next),
    .o_word_offset (w_ifid_imm_next)
  );

  // FSM state register.
  // NOTE: sequential blocks use non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= REDIRECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and memory-request logic, prioritised
  // mispredict > flush > stall > lsd_block > sequential.
  always_comb begin
    // NOTE: every signal assigned here gets a hold/idle default first; a
    // path that forgets one would otherwise infer a latch.
    w_state_next        = r_state;
    w_pc_next           = r_pc;
    w_fetch_pc_next     = r_fetch_pc;
    w_inflight_next     = r_inflight;
    w_ifid_pc_next      = r_ifid_pc;
    w_ifid_instr_next   = r_ifid_instruction;
    w_ifid_valid_next   = r_ifid_valid;
    w_stream_count_next = r_stream_count;
    w_imem_addr         = r_pc;
    w_imem_req          = 1'b0;

    if (ex_mispredict || lsd_flush) begin
      // Redirect: drop the in-flight read, bubble IF/ID (pc kept for the
      // loop detector), refetch from the new target via REDIRECT.
      w_pc_next         = ex_mispredict ? ex_target_pc : lsd_new_pc;
      w_inflight_next   = 1'b0;
      w_ifid_instr_next = NOP_INSTR;
      w_ifid_valid_next = 1'b0;
      w_state_next      = REDIRECT;
    end else if (hazard_stall) begin
      // Everything holds. The data for fetch_pc is on imem_rdata right now
      // and would be lost, so the same address is read again.
      w_imem_addr = r_fetch_pc;
      w_imem_req  = r_inflight;
    end else begin
      unique case (r_state)
        REDIRECT: begin
          // First fetch of the new path; lsd_block is ignored here and
          // re-evaluated once in RUN.
          w_imem_addr       = r_pc;
          w_imem_req        = 1'b1;
          w_pc_next         = r_pc + PC_STEP;
          w_fetch_pc_next   = r_pc;
          w_inflight_next   = 1'b1;
          w_ifid_instr_next = NOP_INSTR;
          w_ifid_valid_next = 1'b0;
          w_state_next      = RUN;
        end

        RUN: begin
          if (lsd_block) begin
            // Hand over to the loop detector; the outstanding read is
            // abandoned and no new one is issued.
            w_inflight_next   = 1'b0;
            w_ifid_instr_next = NOP_INSTR;
            w_ifid_valid_next = 1'b0;
            w_state_next      = STREAM;
          end else begin
            w_imem_addr     = r_pc;
            w_imem_req      = 1'b1;
            w_pc_next       = r_pc + PC_STEP;
            w_fetch_pc_next = r_pc;
            w_inflight_next = 1'b1;
            if (r_inflight) begin
              w_ifid_pc_next    = r_fetch_pc;
              w_ifid_instr_next = imem_rdata;
              w_ifid_valid_next = 1'b1;
            end else begin
              w_ifid_instr_next = NOP_INSTR;
              w_ifid_valid_next = 1'b0;
            end
          end
        end

        STREAM: begin
          if (lsd_block) begin
            w_ifid_pc_next      = lsd_new_pc;
            w_ifid_instr_next   = lsd_instruction;
            w_ifid_valid_next   = 1'b1;
            w_stream_count_next = sat_inc(r_stream_count);
          end else begin
            // Loop exited: lsd_new_pc is the resume address.
            w_pc_next         = lsd_new_pc;
            w_ifid_instr_next = NOP_INSTR;
            w_ifid_valid_next = 1'b0;
            w_state_next      = REDIRECT;
          end
        end

        default: begin
          // Unreachable encoding: recover through a clean refetch.
          w_inflight_next   = 1'b0;
          w_ifid_instr_next = NOP_INSTR;
          w_ifid_valid_next = 1'b0;
          w_state_next      = REDIRECT;
        end
      endcase
    end
  end

  // PC, in-flight tracking, IF/ID register and stream counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc               <= RESET_PC;
      r_fetch_pc         <= RESET_PC;
      r_inflight         <= 1'b0;
      r_ifid_pc          <= 32'h0000_0000;
      r_ifid_instruction <= NOP_INSTR;
      r_ifid_immediate   <= 32'h0000_0000;
      r_ifid_valid       <= 1'b0;
      r_stream_count     <= 32'h0000_0000;
    end else begin
      r_pc               <= w_pc_next;
      r_fetch_pc         <= w_fetch_pc_next;
      r_inflight         <= w_inflight_next;
      r_ifid_pc          <= w_ifid_pc_next;
      r_ifid_instruction <= w_ifid_instr_next;
      r_ifid_immediate   <= w_ifid_imm_next;
      r_ifid_valid       <= w_ifid_valid_next;
      r_stream_count     <= w_stream_count_next;
    end
  end

  // No read strobe may escape while reset is held.
  assign imem_req         = w_imem_req & ~reset;
  assign imem_addr        = w_imem_addr;
  assign ifid_pc          = r_ifid_pc;
  assign ifid_instruction = r_ifid_instruction;
  assign ifid_immediate   = r_ifid_immediate;
  assign ifid_valid       = r_ifid_valid;
  assign stream_count     = r_stream_count;

endmodule : if_fetch_stage
